// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 key-expansion constants and word-level helpers shared by the
// encryption key schedule and the future decryption key path.
package aes_pkg;
   localparam int NK = 4;
   localparam int NR = 10;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   // word 0 is the most significant word (FIPS-197 byte order)
   function automatic logic [31:0] key_word(input logic [127:0] k, input int i);
      return k[127-32*i -: 32];
   endfunction

   function automatic logic [7:0] word_byte(input logic [31:0] w, input int i);
      return w[31-8*i -: 8];
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // sw is SubWord(RotWord(w3)), supplied by the caller's S-box instances
   function automatic logic [127:0] expand(input logic [127:0] k, input logic [31:0] sw,
                                           input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = key_word(k, 0) ^ sw ^ {rc, 24'h0};
      n1 = key_word(k, 1) ^ n0;
      n2 = key_word(k, 2) ^ n1;
      n3 = key_word(k, 3) ^ n2;
      return {n0, n1, n2, n3};
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup, one byte wide.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);
   // entry 0 sits in the top byte, so entry x starts at bit 8*(255-x)
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   assign s_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: zero-latency on-the-fly AES-128 key expansion with K10
// capture and round-sequence checking.
module aes_key_schedule import aes_pkg::*; #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [32*NK-1:0]  key_in,
   input  logic              key_load,
   input  logic              enb_ks,
   input  logic [3:0]        rnd_no,
   output logic [127:0]      round_key,
   output logic              key_valid,
   output logic [127:0]      last_key,
   output logic              last_key_valid,
   output logic              seq_err
);
   localparam logic [3:0] LAST = 4'(NR);

   logic [127:0] kreg_q, kreg_d, last_q, last_d;
   logic [3:0]   exp_q, exp_d;
   logic         lkv_q, lkv_d, err_q, err_d;
   logic [31:0]  rw, sw;
   logic         in_rng, en, ld0, lk_fire;

   assign rw = rot_word(kreg_q[31:0]);

   for (genvar g = 0; g < 4; g++) begin : g_sb
      aes_sbox u_sb (.a_i(rw[31-8*g -: 8]), .s_o(sw[31-8*g -: 8]));
   end

   // a stalled controller drops accept, so key_load gates every state update
   assign in_rng    = rnd_no >= 4'd1 && rnd_no <= LAST;
   assign en        = enb_ks & key_load;
   assign ld0       = en & (rnd_no == 4'd0);
   assign round_key = rnd_no == 4'd0 ? key_in : in_rng ? expand(kreg_q, sw, rcon(rnd_no)) : '0;
   assign key_valid = enb_ks & ((rnd_no == 4'd0 & key_load) | (in_rng & rnd_no == exp_q));
   assign lk_fire   = key_valid & (rnd_no == LAST);

   always_comb begin
      kreg_d = en && rnd_no <= LAST ? round_key : kreg_q;
      exp_d  = ld0 ? 4'd1 : (en && in_rng && rnd_no == exp_q) ? (rnd_no == LAST ? 4'd0 : exp_q + 4'd1) : exp_q;
      err_d  = ld0 ? 1'b0 : err_q | (en && rnd_no != 4'd0 && rnd_no != exp_q);
      last_d = lk_fire ? round_key : last_q;
      lkv_d  = ld0 ? 1'b0 : lkv_q | lk_fire;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kreg_q <= '0;
         exp_q  <= '0;
         last_q <= '0;
         lkv_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         kreg_q <= kreg_d;
         exp_q  <= exp_d;
         last_q <= last_d;
         lkv_q  <= lkv_d;
         err_q  <= err_d;
      end
   end

   assign last_key       = last_q;
   assign last_key_valid = lkv_q;
   assign seq_err        = err_q;
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

On-the-fly AES-128 key expansion stage that sits directly downstream of the AES round controller. It consumes the controller's `rndNo`, `enbKS` and `accept` outputs. It delivers the round key for the current round to the AddRoundKey datapath in the same cycle as that round's `rndNo` value. It also keeps the final round key (K10) for later inverse-cipher use, and flags any round sequencing that deviates from 0,1,…,10.

## Interface
Parameters:
- `NK`, 4: key length in 32-bit words; only 4 (AES-128) is supported.
- `NR`, 10: number of rounds; the last round index.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock shared with the round controller.
- `rst`  input  1  synchronous active-high reset.
- `key_in`  input  128  cipher key; bit 127 is the first key byte (FIPS-197 order).
- `key_load`  input  1  driven from the controller's `accept`; samples `key_in` in round 0.
- `enb_ks`  input  1  key-schedule enable from the controller.
- `rnd_no`  input  4  current round number from the controller, range 0..10.
- `round_key`  output  128  round key for `rnd_no`; combinational from state and inputs.
- `key_valid`  output  1  `round_key` is meaningful this cycle.
- `last_key`  output  128  registered copy of K10.
- `last_key_valid`  output  1  `last_key` holds the K10 of the most recent key.
- `seq_err`  output  1  sticky flag for an out-of-order `rnd_no`.

## Operation
- State:
  - `kreg` (128): the previous round key.
  - `exp_rnd` (4): the next round number expected.
  - `last_key` (128), `last_key_valid`, `seq_err`.
- Key word order: w0 = [127:96], w1 = [95:64], w2 = [63:32], w3 = [31:0].
- Next-key function `expand(k, rc)`:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - RotWord rotates left by one byte.
  - SubWord applies the AES S-box to each of the 4 bytes.
- Rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. Any other `rnd_no` yields 00.
- `round_key`:
  - `key_in` when `rnd_no`==0.
  - `expand(kreg, rcon(rnd_no))` when `rnd_no` is 1..10.
  - All-zero when `rnd_no` > 10.
- `kreg` update: `kreg <= round_key` on every clock with `enb_ks`=1 and `rnd_no` ≤ 10. Otherwise `kreg` holds.
- `exp_rnd` sequence tracker:
  - `key_load`&`enb_ks`&`rnd_no`==0 → `exp_rnd` = 1.
  - `enb_ks`&`rnd_no`==`exp_rnd`, 1..9 → `exp_rnd`+1.
  - `rnd_no`==`exp_rnd`==10 → `exp_rnd` = 0.
- `seq_err`:
  - Set when `enb_ks`=1 and `rnd_no`≠0 and `rnd_no`≠`exp_rnd`.
  - Cleared by `rst` or by a new round-0 `key_load`; the load takes priority over a set in the same cycle.
- `key_valid` = `enb_ks` & ((`rnd_no`==0 & `key_load`) | (`rnd_no` in 1..10 & `rnd_no`==`exp_rnd`)).
- `last_key`:
  - Loaded with `round_key` when `key_valid` and `rnd_no`==10; `last_key_valid` is set in the same cycle.
  - `last_key_valid` clears on a round-0 `key_load`. `last_key` keeps its old value until it is overwritten.

## Timing
- Reset values: `kreg`=0, `exp_rnd`=0, `last_key`=0, `last_key_valid`=0, `seq_err`=0.
- Zero latency: `round_key` for round r is valid in the cycle where `rnd_no`=r. This matches the controller, which increments `rndNo` every cycle while `start` is high.
- Registered outputs (`last_key`, `last_key_valid`, `seq_err`) change on the edge after the qualifying cycle.
- Controller stall (`start` low, `rnd_no` held at r):
  - `kreg` would re-expand every cycle, so `enb_ks` is qualified by `key_load` for rounds ≥ 1.
  - The effective update is `enb_ks` & `key_load`.
  - A held `rnd_no` produces no `kreg` change, no `exp_rnd` change and no `seq_err`.
- Wrap-around: after round 10 the controller returns to 0. With `key_load` high, a new key loads back-to-back with no bubble.
- `rst` mid-encryption: every register returns to its reset value on that edge. `round_key` is still `key_in` if `rnd_no`=0.
- `rnd_no` > 10 with `enb_ks`: sets `seq_err`, leaves `kreg` unchanged, and drives `key_valid`=0.

## Structure
- Shared package `aes_pkg`:
  - `rcon` function/table.
  - `NR`, `NK` constants.
  - Byte-order and word-slice helpers.
  - `expand` function, shared with the future decryption key path.
- One sub-module, `aes_sbox`: a combinational 8-bit lookup, instantiated 4× for SubWord. It is the same S-box the SubBytes stage uses.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, run 11 cycles (rounds 0..10) → `round_key` at r=1 is a0fafe1788542cb123a339392a6c7605, at r=10 is d014f9a8c9ee2589e13f0cc8b6630ca6; `last_key` equals the r=10 value one edge later; `seq_err`=0.
- Hold `key_load` low for 3 cycles at r=4 → `round_key` remains the K4 value (`kreg` and `exp_rnd` unchanged); on resume, K5..K10 match the golden values.
- Drive `rnd_no` sequence 0,1,2,4 → `seq_err` rises one edge after r=4 and `key_valid`=0 at r=4; the next round-0 `key_load` clears `seq_err`.
- Two back-to-back encryptions: all-zero key, then the A.1 key → K1 of the zero key is 62636363626363636263636362636363; the second encryption's keys are unaffected.
- Assert `rst` at r=6 → all registered outputs are 0 the next cycle; a restart from r=0 reproduces the golden schedule.
- `rnd_no`=12 with `enb_ks`=1 → `round_key`=0, `key_valid`=0, `seq_err`=1, `kreg` unchanged.
